dat_mem_ctrl: RTL

- Requester-side controller for the 256 x 8 data memory: it drives the memory's address, write-enable and write-data inputs and consumes its combinational read data.
- On the core side it accepts one-at-a-time LOAD/STORE/PUSH/POP requests over a valid/ready handshake and returns a registered response.
- It owns the hardware stack pointer; the stack grows downward.
- Sits between the processor datapath and the data memory.

---
 rtl/dat_mem_pkg.sv | 30 +++
 rtl/dat_mem_ctrl_stack_ptr.sv | 44 ++++
 rtl/dat_mem_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dat_mem_pkg.sv
// -----------------------------------------------------------------------------
// dat_mem_pkg
// Shared types and constants for the data-memory controller.
//   op_t     : core request opcode (encoding matches the req_op port)
//   state_t  : controller FSM states
//   SP_*_DEF : default stack pointer reset value and full marker
//   MASK_*   : reserved mask-constant region that the stack must never reach
// -----------------------------------------------------------------------------
package dat_mem_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] SP_INIT_DEF  = 8'hFF;
  localparam logic [7:0] SP_LIMIT_DEF = 8'h80;

  localparam logic [7:0] MASK_LO = 8'd60;
  localparam logic [7:0] MASK_HI = 8'd64;

endpackage

// File: rtl/dat_mem_ctrl_stack_ptr.sv
// -----------------------------------------------------------------------------
// stack_ptr
// Hardware stack pointer for a downward-growing stack.
//   clk, rst_n : clock, asynchronous active-low reset (sp <= SP_INIT)
//   inc        : pop strobe, sp <= sp + 1
//   dec        : push strobe, sp <= sp - 1
//   sp         : current stack pointer (next free slot)
//   push_addr  : address the next PUSH writes (sp)
//   pop_addr   : address the next POP reads (sp + 1, modulo 2^AW)
//   full       : sp has reached SP_LIMIT
//   empty      : sp is at SP_INIT
// -----------------------------------------------------------------------------
module stack_ptr #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] SP_INIT  = AW'(dat_mem_pkg::SP_INIT_DEF),
  parameter logic [AW-1:0] SP_LIMIT = AW'(dat_mem_pkg::SP_LIMIT_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] push_addr,
  output logic [AW-1:0] pop_addr,
  output logic          full,
  output logic          empty
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_INIT;
    end else if (dec) begin
      sp <= sp - 1'b1;
    end else if (inc) begin
      sp <= sp + 1'b1;
    end
  end

  assign push_addr = sp;
  assign pop_addr  = sp + 1'b1;
  assign full      = (sp == SP_LIMIT);
  assign empty     = (sp == SP_INIT);

endmodule

// File: rtl/dat_mem_ctrl.sv
// -----------------------------------------------------------------------------
// dat_mem_ctrl
// Requester-side controller for a 256 x 8 data memory with a hardware stack.
// One request at a time: IDLE (accept) -> ACCESS (memory cycle) -> RESP.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : core request handshake
//   req_op              : 0=LOAD 1=STORE 2=PUSH 3=POP
//   req_addr, req_wdata : LOAD/STORE address, STORE/PUSH data
//   rsp_valid/rsp_ready : response handshake
//   rsp_data, rsp_err   : read or written data, stack over/underflow flag
//   sp_out              : current stack pointer
//   mem_addr, mem_wr_en, mem_wdata : memory request side
//   mem_rdata           : combinational memory read data
// -----------------------------------------------------------------------------
module dat_mem_ctrl
  import dat_mem_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] SP_INIT  = AW'(SP_INIT_DEF),
  parameter logic [AW-1:0] SP_LIMIT = AW'(SP_LIMIT_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] sp_out,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state, state_nxt;
  op_t           req_op_e;
  op_t           op_q;
  logic          err_q, err_nxt;
  logic [AW-1:0] ea_q, ea_nxt;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rsp_data_nxt;
  logic          hs;
  logic          sp_inc, sp_dec;
  logic [AW-1:0] push_addr, pop_addr;
  logic          full, empty;

  stack_ptr #(
    .AW       (AW),
    .SP_INIT  (SP_INIT),
    .SP_LIMIT (SP_LIMIT)
  ) u_stack_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (sp_inc),
    .dec       (sp_dec),
    .sp        (sp_out),
    .push_addr (push_addr),
    .pop_addr  (pop_addr),
    .full      (full),
    .empty     (empty)
  );

  assign req_op_e  = op_t'(req_op);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign hs        = req_valid && req_ready;

  // The latched effective address drives the memory directly, so it holds
  // its value outside ACCESS.
  assign mem_addr  = ea_q;
  assign mem_wdata = wdata_q;

  // ---- request stage: effective address and stack error at acceptance ----
  always_comb begin
    ea_nxt  = req_addr;
    err_nxt = 1'b0;
    case (req_op_e)
      OP_PUSH: begin
        ea_nxt  = push_addr;
        err_nxt = full;
      end
      OP_POP: begin
        ea_nxt  = pop_addr;
        err_nxt = empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- access stage: memory strobes, response data, stack pointer move ----
  // Errored stack ops neither write nor move sp and return zero data.
  always_comb begin
    mem_wr_en    = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    rsp_data_nxt = '0;
    if (state == ACCESS) begin
      case (op_q)
        OP_LOAD: rsp_data_nxt = mem_rdata;
        OP_STORE: begin
          mem_wr_en    = 1'b1;
          rsp_data_nxt = wdata_q;
        end
        OP_PUSH: if (!err_q) begin
          mem_wr_en    = 1'b1;
          sp_dec       = 1'b1;
          rsp_data_nxt = wdata_q;
        end
        OP_POP: if (!err_q) begin
          sp_inc       = 1'b1;
          rsp_data_nxt = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_LOAD;
      err_q    <= 1'b0;
      ea_q     <= '0;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_q    <= req_op_e;
        err_q   <= err_nxt;
        ea_q    <= ea_nxt;
        wdata_q <= req_wdata;
      end
      // ---- response stage: captured at the edge closing ACCESS ----
      if (state == ACCESS) begin
        rsp_data <= rsp_data_nxt;
        rsp_err  <= err_q;
      end
    end
  end

endmodule
